// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU operation
// codes, FSM state encoding and datapath select constants.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Codes understood by the ALU operation decoder
  localparam logic [2:0] ALU_IDLE  = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_RTYPE = 3'b111;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_LUI   = 3'b001;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // States that wait on the memory-ready handshake
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ORI:  return ALU_OR;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_output_decoder.sv
// Combinational map from FSM state to the datapath control vector; only the
// fetch-time PC/IR loads additionally depend on the memory-ready input.
module control_output_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic [1:0] o_pc_src,
  output logic       o_i_or_d,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_alu_op
);

  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_pc_src        = PC_SRC_ALU;
    o_i_or_d        = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_reg_dst       = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = SRC_B_REG;
    o_alu_op        = ALU_IDLE;
    case (state_t'(i_state))
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = SRC_B_FOUR;
        o_alu_op    = ALU_ADD;
        o_pc_write  = i_mem_ready;
        o_ir_write  = i_mem_ready;
      end
      // Branch target computed speculatively into ALUOut
      S_DECODE: begin
        o_alu_src_b = SRC_B_IMM_SH2;
        o_alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALU_RTYPE;
      end
      S_WB_R: begin
        o_reg_dst   = 1'b1;
        o_reg_write = 1'b1;
      end
      S_EXEC_I: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = imm_alu_op(i_opcode);
      end
      S_WB_I: begin
        o_reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        o_mem_read = 1'b1;
        o_i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        o_mem_write = 1'b1;
        o_i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = ALU_SUB;
        o_pc_write_cond = 1'b1;
        o_pc_src        = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        o_pc_write = 1'b1;
        o_pc_src   = PC_SRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS sequencer: state register, memory stall/timeout counter and
// illegal-opcode recovery; control outputs come from control_output_decoder.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic [1:0] pc_src_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       illegal_op_o,
  output logic       mem_timeout_o,
  output logic [3:0] state_o
);

  localparam int CW = $clog2(WAIT_LIMIT + 2);

  state_t        r_state;
  logic [5:0]    r_opcode;
  logic [CW-1:0] r_wait_cnt;
  logic          r_illegal;
  logic          r_timeout;

  logic       w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write;
  logic       w_ir_write, w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a;
  logic [1:0] w_pc_src, w_alu_src_b;
  logic [2:0] w_alu_op;
  logic       w_stall;
  logic       w_stall_expired;

  assign w_stall         = is_mem_state(r_state) && !mem_ready_i;
  // True when this stall cycle brings the count up to the limit
  assign w_stall_expired = (int'(r_wait_cnt) + 1) >= WAIT_LIMIT;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_opcode   <= '0;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      if (w_stall) begin
        if (w_stall_expired) begin
          r_state    <= S_FETCH;
          r_wait_cnt <= '0;
          r_timeout  <= 1'b1;
        end else if (r_wait_cnt != '1) begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
      end else begin
        r_wait_cnt <= '0;
        case (r_state)
          S_FETCH:  r_state <= S_DECODE;
          S_DECODE: begin
            r_opcode <= opcode_i;
            case (opcode_i)
              OP_RTYPE:                 r_state <= S_EXEC_R;
              OP_ADDI, OP_ORI, OP_LUI:  r_state <= S_EXEC_I;
              OP_LW, OP_SW:             r_state <= S_MEM_ADDR;
              OP_BEQ:                   r_state <= S_BRANCH;
              OP_J:                     r_state <= S_JUMP;
              default: begin
                r_state   <= S_FETCH;
                r_illegal <= 1'b1;
              end
            endcase
          end
          S_EXEC_R:   r_state <= S_WB_R;
          S_EXEC_I:   r_state <= S_WB_I;
          S_MEM_ADDR: r_state <= (r_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
          S_MEM_RD:   r_state <= S_WB_MEM;
          default:    r_state <= S_FETCH;
        endcase
      end
    end
  end

  control_output_decoder u_decoder (
    .i_state         (r_state),
    .i_opcode        (r_opcode),
    .i_mem_ready     (mem_ready_i),
    .o_pc_write      (w_pc_write),
    .o_pc_write_cond (w_pc_write_cond),
    .o_pc_src        (w_pc_src),
    .o_i_or_d        (w_i_or_d),
    .o_mem_read      (w_mem_read),
    .o_mem_write     (w_mem_write),
    .o_ir_write      (w_ir_write),
    .o_reg_dst       (w_reg_dst),
    .o_mem_to_reg    (w_mem_to_reg),
    .o_reg_write     (w_reg_write),
    .o_alu_src_a     (w_alu_src_a),
    .o_alu_src_b     (w_alu_src_b),
    .o_alu_op        (w_alu_op)
  );

  // Reset forces every control quiet, even before the first clock edge
  assign pc_write_o      = !reset && w_pc_write;
  assign pc_write_cond_o = !reset && w_pc_write_cond;
  assign pc_src_o        = reset ? 2'b00 : w_pc_src;
  assign i_or_d_o        = !reset && w_i_or_d;
  assign mem_read_o      = !reset && w_mem_read;
  assign mem_write_o     = !reset && w_mem_write;
  assign ir_write_o      = !reset && w_ir_write;
  assign reg_dst_o       = !reset && w_reg_dst;
  assign mem_to_reg_o    = !reset && w_mem_to_reg;
  assign reg_write_o     = !reset && w_reg_write;
  assign alu_src_a_o     = !reset && w_alu_src_a;
  assign alu_src_b_o     = reset ? 2'b00 : w_alu_src_b;
  assign alu_op_o        = reset ? 3'b000 : w_alu_op;
  assign illegal_op_o    = !reset && r_illegal;
  assign mem_timeout_o   = !reset && r_timeout;
  assign state_o         = reset ? S_FETCH : r_state;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style finite state machine that sequences the multicycle MIPS datapath: register file, memory, PC, IR and the ALU through its `alu_op_o` code, which feeds the ALU operation decoder. It walks each instruction through fetch, decode, execute, memory and write-back. It stalls on a memory-ready handshake. It recovers from unsupported opcodes without hanging the core.

## Interface
- `WAIT_LIMIT`, default 15: maximum consecutive stall cycles on one memory access before `mem_timeout_o` pulses.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `opcode_i` input 6: IR[31:26]. Sampled only in DECODE.
- `mem_ready_i` input 1: memory completes the current access this cycle.
- `pc_write_o` output 1: unconditional PC load.
- `pc_write_cond_o` output 1: PC load when ALU zero is set (BEQ).
- `pc_src_o` output 2: 00 ALU result, 01 ALUOut register, 10 jump target.
- `i_or_d_o` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read_o`, `mem_write_o` output 1 each: memory strobes.
- `ir_write_o` output 1: IR load.
- `reg_dst_o` output 1: destination select; 0 = rt, 1 = rd.
- `mem_to_reg_o` output 1: write-back select; 0 = ALUOut, 1 = MDR.
- `reg_write_o` output 1: register file write enable.
- `alu_src_a_o` output 1: ALU A select; 0 = PC, 1 = register A.
- `alu_src_b_o` output 2: ALU B select; 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- `alu_op_o` output 3: 000 idle, 100 add, 011 subtract, 111 R-type (decoder uses funct), 010 or, 001 lui.
- `illegal_op_o` output 1: one-cycle pulse on an unsupported opcode.
- `mem_timeout_o` output 1: one-cycle pulse when `WAIT_LIMIT` is exceeded.
- `state_o` output 4: current state, for debug.

## Operation
- Opcodes: R 000000, ADDI 001000, ORI 001101, LUI 001111, LW 100011, SW 101011, BEQ 000100, J 000010.
- States and their asserted outputs (all others 0):
  - FETCH: mem_read, alu_src_b=01, alu_op=100. pc_write and ir_write only when `mem_ready_i`=1. Holds until ready. Then goes to DECODE.
  - DECODE: alu_src_b=11, alu_op=100 (branch target into ALUOut). Next state by opcode:
    - R → EXEC_R
    - ADDI/ORI/LUI → EXEC_I
    - LW/SW → MEM_ADDR
    - BEQ → BRANCH
    - J → JUMP
    - other → FETCH with an `illegal_op_o` pulse
  - EXEC_R: alu_src_a=1, alu_op=111. Goes to WB_R.
  - WB_R: reg_dst=1, reg_write. Goes to FETCH.
  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_op = 100 (ADDI), 010 (ORI) or 001 (LUI). Goes to WB_I.
  - WB_I: reg_write, reg_dst=0. Goes to FETCH.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=100. Goes to MEM_RD (LW) or MEM_WR (SW).
  - MEM_RD: mem_read, i_or_d=1. Holds until ready. Then goes to WB_MEM.
  - WB_MEM: reg_write, mem_to_reg=1. Goes to FETCH.
  - MEM_WR: mem_write, i_or_d=1. Holds until ready. Then goes to FETCH.
  - BRANCH: alu_src_a=1, alu_op=011, pc_write_cond, pc_src=01. Goes to FETCH.
  - JUMP: pc_write, pc_src=10. Goes to FETCH.
- The opcode used in EXEC_I and MEM_ADDR is the value latched in DECODE, held in an internal 6-bit register.
- Wait counter:
  - Increments each cycle a memory state holds with ready=0.
  - Clears on state exit.
  - When the count reaches `WAIT_LIMIT`, `mem_timeout_o` pulses once. The FSM returns to FETCH, abandoning the access. In FETCH, the access restarts at the same PC.
  - Saturating; never wraps.

## Timing
- State register updates on the rising edge of `clk`. Outputs decode combinationally from the state register, plus `mem_ready_i` for pc_write and ir_write only.
- `reset`=1 at an edge puts the state in FETCH and clears the wait counter and latched opcode. While `reset` is high, every output is 0; `state_o` reads FETCH.
- Reset mid-instruction abandons it. No write strobe is asserted in the reset cycle or the cycle that follows it.
- Zero-wait latencies (FETCH to FETCH): R, ADDI, ORI, LUI, SW take 4 cycles; LW 5; BEQ and J 3; illegal 2. Each memory wait cycle adds 1.
- `mem_ready_i` may be high in the first cycle of a memory state. The access then completes that cycle.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode constants
  - `alu_op` codes (shared with the ALU operation decoder)
  - state encoding
  - `pc_src` and `alu_src_b` select constants
- Sub-module `control_output_decoder`: combinational state → control vector. The FSM top keeps the next-state logic, the wait counter and the pulse generation.

## Test plan
- ADDI with `mem_ready_i` tied 1 → states FETCH, DECODE, EXEC_I, WB_I, FETCH. `alu_op_o`=100 in EXEC_I, `reg_write_o`=1 only in WB_I. 4 cycles total.
- LW with ready low for 3 cycles in MEM_RD → MEM_RD held 4 cycles, `mem_read_o` and `i_or_d_o` high throughout, then WB_MEM with `mem_to_reg_o`=1. 8 cycles total.
- Opcode 111111 → DECODE goes to FETCH, `illegal_op_o` high for exactly 1 cycle, no write strobes.
- BEQ → BRANCH with `alu_op_o`=011, `pc_write_cond_o`=1, `pc_src_o`=01. J → `pc_write_o`=1, `pc_src_o`=10.
- Ready held 0 in FETCH with `WAIT_LIMIT`=15 → `mem_timeout_o` pulses once, state stays FETCH, `ir_write_o` never asserts.
- `reset` asserted during MEM_WR → next cycle state is FETCH, all outputs 0 while reset is high, `mem_write_o` low after release until the next SW.
